// File: rtl/dm_pkg.sv
// rtl/dm_pkg.sv - shared state encoding, byte-enable constants and helpers for the data-memory responder
package dm_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dm_state_e;

    localparam logic [3:0] BE_WORD    = 4'b1111;
    localparam logic [3:0] BE_HALF_LO = 4'b0011;
    localparam logic [3:0] BE_HALF_HI = 4'b1100;

    localparam int CNT_W = 4;

    function automatic logic [31:0] be_to_mask(input logic [3:0] be);
        logic [31:0] m;
        m = '0;
        for (int i = 0; i < 4; i++) begin
            m[8*i +: 8] = {8{be[i]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/dm_responder_if.sv
// rtl/dm_responder_if.sv - request/response handshake bundle between the MEM stage and the responder
interface dm_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [3:0]  req_be;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_we, req_addr, req_be, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_be, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/dm_be_check.sv
// rtl/dm_be_check.sv - alignment/range checker and lane-mask expansion for a latched request
module dm_be_check
    import dm_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024
) (
    input  logic [31:0] addr_i,
    input  logic [3:0]  be_i,
    output logic        err_o,
    output logic [31:0] mask_o
);

    logic align_ok;
    logic range_ok;

    always_comb begin
        align_ok = 1'b0;
        case (be_i)
            BE_WORD:                             align_ok = (addr_i[1:0] == 2'b00);
            BE_HALF_LO, BE_HALF_HI:              align_ok = !addr_i[0];
            4'b0001, 4'b0010, 4'b0100, 4'b1000:  align_ok = 1'b1;
            default:                             align_ok = 1'b0;
        endcase
        // Full upper address takes part so high addresses never alias onto the array.
        range_ok = ({2'b00, addr_i[31:2]} < 32'(DEPTH_WORDS));
        err_o    = !align_ok || !range_ok;
        mask_o   = be_to_mask(be_i);
    end

endmodule

// File: rtl/dm_responder.sv
// rtl/dm_responder.sv - wait-state data-memory responder: accept, delay, byte-enabled access, respond
module dm_responder
    import dm_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic clk,
    input  logic reset,
    dm_responder_if.slave bus
);

    localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(WAIT_CYCLES);

    dm_state_e        state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             we_q;
    logic [31:0]      addr_q;
    logic [3:0]       be_q;
    logic [31:0]      wdata_q;
    logic             req_ready_q;
    logic             resp_valid_q;
    logic [31:0]      resp_rdata_q;
    logic             resp_err_q;
    logic [31:0]      mem_q [DEPTH_WORDS];

    logic             err;
    logic [31:0]      mask;
    logic [IDX_W-1:0] idx;
    logic [31:0]      word_d;
    logic [31:0]      rdata_d;

    dm_be_check #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_be_check (
        .addr_i (addr_q),
        .be_i   (be_q),
        .err_o  (err),
        .mask_o (mask)
    );

    assign idx     = addr_q[IDX_W+1:2];
    assign word_d  = (mem_q[idx] & ~mask) | (wdata_q & mask);
    assign rdata_d = (!err && !we_q) ? (mem_q[idx] & mask) : 32'h0;

    // The counter runs down to zero so that resp_valid rises WAIT_CYCLES+1 edges after accept.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            be_q         <= '0;
            wdata_q      <= '0;
            req_ready_q  <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
            for (int i = 0; i < DEPTH_WORDS; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    req_ready_q <= 1'b1;
                    if (bus.req_valid && req_ready_q) begin
                        we_q        <= bus.req_we;
                        addr_q      <= bus.req_addr;
                        be_q        <= bus.req_be;
                        wdata_q     <= bus.req_wdata;
                        cnt_q       <= WAIT_INIT;
                        req_ready_q <= 1'b0;
                        state_q     <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt_q == '0) begin
                        state_q      <= RESP;
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= err;
                        resp_rdata_q <= rdata_d;
                        if (!err && we_q) begin
                            mem_q[idx] <= word_d;
                        end
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                RESP: begin
                    if (bus.resp_ready) begin
                        state_q      <= IDLE;
                        resp_valid_q <= 1'b0;
                        resp_rdata_q <= '0;
                        resp_err_q   <= 1'b0;
                        req_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready  = req_ready_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.resp_err   = resp_err_q;

endmodule

// File: tb/tb_dm_responder.sv
// tb/tb_dm_responder.sv - directed and randomized bench for dm_responder against a byte-array memory model
module tb_dm_responder;

    localparam int DEPTH = 1024;
    localparam int WAITC = 2;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    dm_responder_if bus ();
    dm_responder_if bus0 ();

    dm_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WAITC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    dm_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0.slave)
    );

    int npass = 0;
    int ntot  = 0;
    logic [7:0] model_mem [DEPTH*4];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntot++;
        assert (obs === exp) npass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic bit exp_err(input logic [31:0] a, input logic [3:0] be);
        bit legal;
        int ones;
        ones = $countones(be);
        if (ones == 1) legal = 1'b1;
        else if (be == 4'd3 || be == 4'd12) legal = (a % 2 == 0);
        else if (be == 4'd15) legal = (a % 4 == 0);
        else legal = 1'b0;
        return !legal || (a / 4 >= DEPTH);
    endfunction

    function automatic logic [31:0] exp_load(input logic [31:0] a, input logic [3:0] be);
        logic [31:0] r;
        int base;
        r = 0;
        base = (a / 4) * 4;
        for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = model_mem[base + i];
        return r;
    endfunction

    task automatic model_store(input logic [31:0] a, input logic [3:0] be, input logic [31:0] wd);
        int base;
        base = (a / 4) * 4;
        for (int i = 0; i < 4; i++) if (be[i]) model_mem[base + i] = wd[8*i +: 8];
    endtask

    task automatic model_clear();
        for (int i = 0; i < DEPTH*4; i++) model_mem[i] = 8'h00;
    endtask

    task automatic wait_resp(output int lat);
        lat = 0;
        while (!bus.resp_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic txn(input bit we, input logic [31:0] a, input logic [3:0] be,
                       input logic [31:0] wd, input int hold, input string tag);
        bit e;
        logic [31:0] exp_rd;
        int lat;
        int guard;
        e = exp_err(a, be);
        exp_rd = (!we && !e) ? exp_load(a, be) : 32'h0;
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_we = we; bus.req_addr = a;
        bus.req_be = be; bus.req_wdata = wd; bus.resp_ready = 1'b0;
        guard = 0;
        while (!bus.req_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check({tag, ":req_ready"}, 32'(bus.req_ready), 32'd1);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        wait_resp(lat);
        check({tag, ":latency"}, 32'(lat), 32'(WAITC + 1));
        check({tag, ":rdata"}, bus.resp_rdata, exp_rd);
        check({tag, ":err"}, 32'(bus.resp_err), 32'(e));
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            check({tag, ":hold_valid"}, 32'(bus.resp_valid), 32'd1);
            check({tag, ":hold_rdata"}, bus.resp_rdata, exp_rd);
            check({tag, ":hold_ready"}, 32'(bus.req_ready), 32'd0);
        end
        @(negedge clk);
        bus.resp_ready = 1'b1;
        @(posedge clk); #1;
        check({tag, ":valid_clr"}, 32'(bus.resp_valid), 32'd0);
        check({tag, ":rdata_clr"}, bus.resp_rdata, 32'h0);
        bus.resp_ready = 1'b0;
        if (we && !e) model_store(a, be, wd);
    endtask

    initial begin
        int lat;
        logic [31:0] held;
        bus.req_valid = 0; bus.req_we = 0; bus.req_addr = 0; bus.req_be = 0;
        bus.req_wdata = 0; bus.resp_ready = 0;
        bus0.req_valid = 0; bus0.req_we = 0; bus0.req_addr = 0; bus0.req_be = 0;
        bus0.req_wdata = 0; bus0.resp_ready = 0;
        model_clear();

        repeat (3) @(negedge clk);
        check("rst:req_ready", 32'(bus.req_ready), 32'd0);
        check("rst:resp_valid", 32'(bus.resp_valid), 32'd0);
        check("rst:rdata", bus.resp_rdata, 32'h0);
        reset = 1'b1;
        @(posedge clk); #1;
        check("rel:req_ready", 32'(bus.req_ready), 32'd1);
        check("rel:resp_valid", 32'(bus.resp_valid), 32'd0);

        txn(0, 32'h10, 4'hF, 0, 0, "load_zero");
        txn(1, 32'h40, 4'hF, 32'hDEADBEEF, 0, "store_word");
        txn(0, 32'h40, 4'hF, 0, 0, "load_word");
        txn(1, 32'h41, 4'b0010, 32'h0000AB00, 0, "store_byte");
        txn(0, 32'h40, 4'hF, 0, 0, "load_merged");
        check("merged_model", exp_load(32'h40, 4'hF), 32'hDEADABEF);
        txn(0, 32'h42, 4'b1100, 0, 0, "load_half_hi");
        txn(1, 32'h42, 4'hF, 32'h12345678, 0, "err_misalign");
        txn(0, 32'h40, 4'hF, 0, 0, "load_unchanged");
        txn(0, 32'h1000, 4'hF, 0, 0, "err_range");
        txn(0, 32'h44, 4'b0101, 0, 0, "err_be");

        // Backpressure with a second request held pending throughout RESP.
        @(negedge clk);
        bus.req_valid = 1; bus.req_we = 0; bus.req_addr = 32'h40; bus.req_be = 4'hF;
        bus.resp_ready = 0;
        @(posedge clk); #1;
        bus.req_we = 1; bus.req_addr = 32'h44; bus.req_wdata = 32'hCAFEF00D;
        wait_resp(lat);
        check("bp:latency", 32'(lat), 32'(WAITC + 1));
        check("bp:rdata", bus.resp_rdata, exp_load(32'h40, 4'hF));
        held = bus.resp_rdata;
        for (int h = 0; h < 5; h++) begin
            @(posedge clk); #1;
            check("bp:valid", 32'(bus.resp_valid), 32'd1);
            check("bp:rdata_stable", bus.resp_rdata, held);
            check("bp:err_stable", 32'(bus.resp_err), 32'd0);
            check("bp:req_ready", 32'(bus.req_ready), 32'd0);
        end
        @(negedge clk); bus.resp_ready = 1;
        @(posedge clk); #1;
        check("bp:valid_clr", 32'(bus.resp_valid), 32'd0);
        check("bp:idle_ready", 32'(bus.req_ready), 32'd1);
        bus.resp_ready = 0;
        @(posedge clk); #1;
        check("bp:second_accept", 32'(bus.req_ready), 32'd0);
        bus.req_valid = 0;
        wait_resp(lat);
        check("bp:second_latency", 32'(lat), 32'(WAITC + 1));
        @(negedge clk); bus.resp_ready = 1;
        @(posedge clk); #1;
        bus.resp_ready = 0;
        model_store(32'h44, 4'hF, 32'hCAFEF00D);
        txn(0, 32'h44, 4'hF, 0, 1, "bp:readback");

        for (int n = 0; n < 30; n++) begin
            logic [31:0] a;
            a = ($urandom_range(0, 9) == 0) ? 32'h1000 + $urandom_range(0, 63) : 32'($urandom_range(0, 127));
            txn(bit'($urandom_range(0, 1)), a, 4'($urandom_range(0, 15)), $urandom,
                $urandom_range(0, 2), "rand");
        end

        // Reset during WAIT of a store must leave no trace of it.
        @(negedge clk);
        bus.req_valid = 1; bus.req_we = 1; bus.req_addr = 32'h80; bus.req_be = 4'hF;
        bus.req_wdata = 32'h5A5AA5A5;
        @(posedge clk); #1;
        bus.req_valid = 0;
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        check("mid_rst:resp_valid", 32'(bus.resp_valid), 32'd0);
        check("mid_rst:req_ready", 32'(bus.req_ready), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        model_clear();
        @(posedge clk); #1;
        check("mid_rst:resp_valid_after", 32'(bus.resp_valid), 32'd0);
        check("mid_rst:ready_after", 32'(bus.req_ready), 32'd1);
        txn(0, 32'h80, 4'hF, 0, 0, "mid_rst:load");

        // Zero wait states: resp_valid on the edge after accept.
        @(negedge clk);
        bus0.req_valid = 1; bus0.req_we = 1; bus0.req_addr = 32'h10; bus0.req_be = 4'hF;
        bus0.req_wdata = 32'h0BADF00D; bus0.resp_ready = 0;
        check("w0:ready", 32'(bus0.req_ready), 32'd1);
        @(posedge clk); #1;
        bus0.req_valid = 0;
        check("w0:not_yet", 32'(bus0.resp_valid), 32'd0);
        @(posedge clk); #1;
        check("w0:valid", 32'(bus0.resp_valid), 32'd1);
        check("w0:err", 32'(bus0.resp_err), 32'd0);
        @(negedge clk); bus0.resp_ready = 1;
        @(posedge clk); #1;
        bus0.resp_ready = 0;
        @(negedge clk);
        bus0.req_valid = 1; bus0.req_we = 0; bus0.req_be = 4'b0011;
        @(posedge clk); #1;
        bus0.req_valid = 0;
        @(posedge clk); #1;
        check("w0:load_valid", 32'(bus0.resp_valid), 32'd1);
        check("w0:load_rdata", bus0.resp_rdata, 32'h0000F00D);
        @(negedge clk); bus0.resp_ready = 1;
        @(posedge clk); #1;
        bus0.resp_ready = 0;

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: observed no finish, expected finish");
        $fatal(1, "timeout");
    end

endmodule
